// File: rtl/regfile_access_arbiter.sv
`default_nettype none
// ============================================================================
// regfile_access_arbiter : shares the file-register port between the core and
// a debug requester, sequencing the two-cycle (address, then data) debug access.
// Build option: REGFILE_CLEAR_ON_RESET_EN adds a post-reset zeroing sweep.
// Revision: 1.0
// ============================================================================
module regfile_access_arbiter #(
   parameter logic [8:0] CLR_FIRST = 9'h020,
   parameter logic [8:0] CLR_LAST  = 9'h07F
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [8:0] core_addr,
   input  logic       core_wr_en,
   input  logic [7:0] core_data_in,
   input  logic       core_halted,
   output logic       core_stall,
   input  logic       dbg_req,
   input  logic       dbg_we,
   input  logic [8:0] dbg_addr,
   input  logic [7:0] dbg_wdata,
   output logic       dbg_ack,
   output logic [7:0] dbg_rdata,
   output logic       dbg_busy,
   output logic [8:0] rf_addr,
   output logic       rf_wr_en,
   output logic [7:0] rf_data_in,
   input  logic [7:0] rf_data_out
);

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_DBG_ADDR = 3'd1;
   localparam logic [2:0] ST_DBG_XFER = 3'd2;
   localparam logic [2:0] ST_DBG_ACK  = 3'd3;
`ifdef REGFILE_CLEAR_ON_RESET_EN
   localparam logic [2:0] ST_CLEAR    = 3'd4;
   localparam logic [2:0] ST_RESET    = ST_CLEAR;
   // Sweep index of the final cycle, which writes CLR_LAST.
   localparam logic [9:0] CLR_LAST_IDX =
      10'({1'b0, CLR_LAST}) - 10'({1'b0, CLR_FIRST}) + 10'd1;
`else
   localparam logic [2:0] ST_RESET    = ST_IDLE;
`endif

   if (CLR_LAST < CLR_FIRST) begin : g_bad_clr_range
      $error("regfile_access_arbiter: CLR_LAST must not be below CLR_FIRST");
   end

   logic [2:0] state_q, state_d;
   logic [8:0] addr_q;
   logic       we_q;
   logic [7:0] wdata_q;
   logic [7:0] rdata_q;
   logic       accept;

   assign accept = (state_q == ST_IDLE) && dbg_req && core_halted;

`ifdef REGFILE_CLEAR_ON_RESET_EN
   logic [9:0] clr_cnt_q;

   always_ff @(posedge clk) begin
      if (rst)
         clr_cnt_q <= '0;
      else if (state_q == ST_CLEAR)
         clr_cnt_q <= clr_cnt_q + 10'd1;
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_RESET;
         addr_q  <= '0;
         we_q    <= 1'b0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            addr_q  <= dbg_addr;
            we_q    <= dbg_we;
            wdata_q <= dbg_wdata;
         end
         // Captured for writes too, so a write returns the pre-write value.
         if (state_q == ST_DBG_XFER)
            rdata_q <= rf_data_out;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:     if (accept) state_d = ST_DBG_ADDR;
         ST_DBG_ADDR: state_d = ST_DBG_XFER;
         ST_DBG_XFER: state_d = ST_DBG_ACK;
         ST_DBG_ACK:  if (!dbg_req) state_d = ST_IDLE;
`ifdef REGFILE_CLEAR_ON_RESET_EN
         ST_CLEAR:    if (clr_cnt_q == CLR_LAST_IDX) state_d = ST_IDLE;
`endif
         default:     state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      rf_addr    = core_addr;
      rf_wr_en   = core_wr_en;
      rf_data_in = core_data_in;
      dbg_busy   = 1'b0;
      dbg_ack    = 1'b0;
      core_stall = 1'b0;
      case (state_q)
         ST_DBG_ADDR: begin
            rf_addr    = addr_q;
            rf_wr_en   = 1'b0;
            rf_data_in = wdata_q;
            dbg_busy   = 1'b1;
         end
         ST_DBG_XFER: begin
            rf_addr    = addr_q;
            rf_wr_en   = we_q;
            rf_data_in = wdata_q;
            dbg_busy   = 1'b1;
         end
         // Re-presenting core_addr reloads the file-register address latch so
         // the next core write cannot land on the debug address.
         ST_DBG_ACK: begin
            rf_wr_en = 1'b0;
            dbg_busy = 1'b1;
            dbg_ack  = 1'b1;
         end
`ifdef REGFILE_CLEAR_ON_RESET_EN
         ST_CLEAR: begin
            core_stall = 1'b1;
            rf_data_in = 8'h00;
            if (clr_cnt_q == 10'd0) begin
               rf_addr  = CLR_FIRST;
               rf_wr_en = 1'b0;
            end else if (clr_cnt_q == CLR_LAST_IDX) begin
               rf_wr_en = 1'b1;
            end else begin
               rf_addr  = CLR_FIRST + clr_cnt_q[8:0];
               rf_wr_en = 1'b1;
            end
         end
`endif
         default: ;
      endcase
   end

   assign dbg_rdata = rdata_q;

endmodule
`default_nettype wire
